// File: rtl/cavlc_shift_ctrl.sv
// Shift sequencer/arbiter for the CAVLC bitstream barrel shifter: cold-start fill,
// then round-robin shift grants to four syntax-element decoders under a bit budget.
module cavlc_shift_ctrl (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        Start,
   input  logic        Stop,
   input  logic [23:0] BitBudget,
   input  logic [3:0]  Req,
   input  logic [19:0] ReqLen,
   output logic [3:0]  Grant,
   output logic        WindowValid,
   output logic        ShifterEnable,
   output logic        ShiftEn,
   output logic [4:0]  NumShift,
   input  logic        ShifterReady,
   output logic [23:0] BitsUsed,
   output logic        Busy,
   output logic        Done,
   output logic        Overrun,
   output logic        LenError
);
   localparam int NUM_REQ = 4;
   localparam int MAX_LEN = 16;

   typedef enum logic [2:0] {IDLE, FILL, SETTLE, RUN, SHIFT, END} state_t;

   state_t                   state;
   logic [1:0]               ptr;
   logic [23:0]              budget;
   logic [NUM_REQ-1:0][4:0]  lens;
   logic                     winFound;
   logic [1:0]               win;
   logic [4:0]               winLen;
   logic [24:0]              sum;
   logic                     overBudget;

   assign lens = ReqLen;

   // Walk offsets high to low so the requester closest to the pointer wins.
   always_comb begin
      winFound = 1'b0;
      win      = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (Req[ptr + 2'(k)]) begin
            winFound = 1'b1;
            win      = ptr + 2'(k);
         end
      end
      winLen     = lens[win];
      sum        = {1'b0, BitsUsed} + 25'(winLen);
      overBudget = sum > {1'b0, budget};
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state         <= IDLE;
         ptr           <= '0;
         budget        <= '0;
         Grant         <= '0;
         WindowValid   <= 1'b0;
         ShifterEnable <= 1'b0;
         ShiftEn       <= 1'b0;
         NumShift      <= '0;
         BitsUsed      <= '0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Overrun       <= 1'b0;
         LenError      <= 1'b0;
      end else begin
         Grant    <= '0;
         ShiftEn  <= 1'b0;
         NumShift <= '0;
         Done     <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  budget        <= BitBudget;
                  BitsUsed      <= '0;
                  Overrun       <= 1'b0;
                  LenError      <= 1'b0;
                  ShifterEnable <= 1'b1;
                  Busy          <= 1'b1;
                  state         <= FILL;
               end
            end
            FILL: begin
               if (Stop) begin
                  Done  <= 1'b1;
                  state <= END;
               end else if (ShifterReady) begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               WindowValid <= 1'b1;
               state       <= RUN;
            end
            RUN: begin
               if (Stop) begin
                  Done        <= 1'b1;
                  WindowValid <= 1'b0;
                  state       <= END;
               end else if (winFound) begin
                  if (winLen > 5'(MAX_LEN)) begin
                     LenError    <= 1'b1;
                     Done        <= 1'b1;
                     WindowValid <= 1'b0;
                     state       <= END;
                  end else if (overBudget) begin
                     Overrun     <= 1'b1;
                     Done        <= 1'b1;
                     WindowValid <= 1'b0;
                     state       <= END;
                  end else begin
                     Grant[win]  <= 1'b1;
                     ShiftEn     <= 1'b1;
                     NumShift    <= winLen;
                     BitsUsed    <= sum[23:0];
                     ptr         <= win + 2'd1;
                     WindowValid <= 1'b0;
                     state       <= SHIFT;
                  end
               end
            end
            SHIFT: state <= SETTLE;
            END: begin
               ShifterEnable <= 1'b0;
               Busy          <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cavlc_shift_ctrl.sv
// Directed bench for cavlc_shift_ctrl: cold start, round-robin, budget edge,
// illegal length, stop during traffic, stop in fill and reset mid-run.
module tb_cavlc_shift_ctrl;
   logic        Clk = 1'b0;
   logic        nReset;
   logic        Start, Stop, ShifterReady;
   logic [23:0] BitBudget;
   logic [3:0]  Req;
   logic [19:0] ReqLen;
   logic [3:0]  Grant;
   logic        WindowValid, ShifterEnable, ShiftEn, Busy, Done, Overrun, LenError;
   logic [4:0]  NumShift;
   logic [23:0] BitsUsed;

   int nVec  = 0;
   int nMiss = 0;

   cavlc_shift_ctrl dut (
      .Clk(Clk), .nReset(nReset), .Start(Start), .Stop(Stop), .BitBudget(BitBudget),
      .Req(Req), .ReqLen(ReqLen), .Grant(Grant), .WindowValid(WindowValid),
      .ShifterEnable(ShifterEnable), .ShiftEn(ShiftEn), .NumShift(NumShift),
      .ShifterReady(ShifterReady), .BitsUsed(BitsUsed), .Busy(Busy), .Done(Done),
      .Overrun(Overrun), .LenError(LenError)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      if (obs !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Start a run with ShifterReady already high; returns in the first RUN cycle.
   task automatic startRun(input logic [23:0] bud);
      BitBudget = bud;
      Start     = 1'b1;
      step();
      Start = 1'b0;
      step();
      step();
   endtask

   initial begin
      nReset = 1'b0; Start = 1'b0; Stop = 1'b0; ShifterReady = 1'b0;
      BitBudget = '0; Req = '0; ReqLen = '0;
      step(); step();
      chk("rst_out", {Grant, WindowValid, ShifterEnable, ShiftEn, NumShift, Busy, Done,
                      Overrun, LenError}, 32'h0);
      chk("rst_bits", BitsUsed, 0);
      #3 nReset = 1'b1;
      step();

      // Cold start: ready arrives 10 cycles after Start
      BitBudget = 24'd100;
      Start     = 1'b1;
      step();
      Start = 1'b0;
      chk("cold_en", {ShifterEnable, Busy, WindowValid}, 3'b110);
      for (int i = 0; i < 9; i++) step();
      chk("cold_wv_wait", WindowValid, 0);
      ShifterReady = 1'b1;
      step();
      chk("cold_settle_wv", WindowValid, 0);
      step();
      chk("cold_run_wv", WindowValid, 1);

      // Round-robin, all lengths 3
      ReqLen = {5'd3, 5'd3, 5'd3, 5'd3};
      Req    = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_grant", Grant, 32'(4'b0001 << (i % 4)));
         chk("rr_shift", {ShiftEn, NumShift, WindowValid}, {1'b1, 5'd3, 1'b0});
         chk("rr_bits", BitsUsed, 32'(3 * (i + 1)));
         step();
         chk("rr_gap", {Grant, ShiftEn, NumShift, WindowValid}, 11'b0);
         step();
         chk("rr_wv", {Grant, WindowValid}, 5'b00001);
      end
      chk("rr_total", BitsUsed, 15);

      // Stop while requester 1 is pending
      Req  = 4'b0010;
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      Req  = 4'b0000;
      chk("stop_nogrant", Grant, 0);
      chk("stop_done", {Done, Busy, ShifterEnable}, 3'b111);
      chk("stop_bits", BitsUsed, 15);
      step();
      chk("stop_idle", {Done, Busy, ShifterEnable}, 3'b000);
      chk("stop_bits_hold", BitsUsed, 15);

      // Budget edge: exact-fit grant, then one bit too many
      startRun(24'd16);
      chk("bud_clr", {BitsUsed, WindowValid}, 25'h1);
      Req    = 4'b0010;
      ReqLen = {5'd0, 5'd0, 5'd16, 5'd0};
      step();
      chk("bud_grant", Grant, 4'b0010);
      chk("bud_num", NumShift, 16);
      chk("bud_bits", BitsUsed, 16);
      Req = 4'b0000;
      step(); step();
      Req    = 4'b0100;
      ReqLen = {5'd0, 5'd1, 5'd0, 5'd0};
      step();
      chk("bud_nogrant", {Grant, ShiftEn}, 5'b0);
      chk("bud_over", {Overrun, Done, LenError}, 3'b110);
      chk("bud_bits_hold", BitsUsed, 16);
      Req = 4'b0000;
      step();
      chk("bud_idle", {Busy, Done, ShifterEnable, Overrun}, 4'b0001);

      // Illegal length on requester 3
      startRun(24'd100);
      chk("len_clr_over", Overrun, 0);
      Req    = 4'b1000;
      ReqLen = {5'd17, 5'd0, 5'd0, 5'd0};
      step();
      chk("len_nogrant", Grant, 0);
      chk("len_err", {LenError, Done, Overrun}, 3'b110);
      Req = 4'b0000;
      step();
      chk("len_off", {ShifterEnable, Busy, LenError}, 3'b001);

      // Stop while still filling
      ShifterReady = 1'b0;
      BitBudget    = 24'd50;
      Start        = 1'b1;
      step();
      Start = 1'b0;
      Stop  = 1'b1;
      step();
      Stop = 1'b0;
      chk("fill_stop", {Done, Busy, ShifterEnable}, 3'b111);
      step();
      chk("fill_stop_idle", {Done, Busy}, 2'b00);
      ShifterReady = 1'b1;

      // Reset mid-run: pointer is at 2 here, so all-request grants requester 2
      startRun(24'd100);
      Req    = 4'b1111;
      ReqLen = {5'd3, 5'd3, 5'd3, 5'd3};
      step();
      chk("mid_grant", Grant, 4'b0100);
      nReset = 1'b0;
      #1;
      chk("mid_rst_out", {Grant, WindowValid, ShifterEnable, ShiftEn, NumShift, Busy,
                          Done}, 14'b0);
      chk("mid_rst_bits", BitsUsed, 0);
      Req = 4'b0000;
      step(); step();
      chk("mid_no_done", {Done, Busy}, 2'b00);
      #3 nReset = 1'b1;
      step();
      startRun(24'd100);
      Req = 4'b1111;
      step();
      chk("mid_ptr0", Grant, 4'b0001);
      chk("mid_bits", BitsUsed, 3);
      Req  = 4'b0000;
      step(); step();
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      chk("mid_end", Done, 1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end
endmodule

// File: doc/cavlc_shift_ctrl.md
# cavlc_shift_ctrl

Sequencer and arbiter for the bitstream barrel shifter in the CAVLC decode path. It brings the shifter up from cold, then round-robins up to four syntax-element decoders for shift grants. Each decoder is a requester (coeff_token, trailing-ones/level, total_zeros, run_before). Each grant forwards the winner's consumed length to the shifter and is charged against a per-block bit budget. It also tells requesters when the 16-bit window is valid to inspect.

## Interface
- No parameters; requester count fixed at 4, budget width fixed at 24 bits.
- Clk  in  1  clock
- nReset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; begin a decode run (ignored unless IDLE)
- Stop  in  1  level; end run at next arbitration point
- BitBudget  in  24  max bits consumable in this run, sampled on Start
- Req  in  4  per-requester shift request; held until granted
- ReqLen  in  20  packed 5-bit lengths, requester i at [5i+4:5i], legal 0..16
- Grant  out  4  one-hot, one-cycle grant pulse
- WindowValid  out  1  shifter output reflects all granted shifts
- ShifterEnable  out  1  drives shifter Enable
- ShiftEn  out  1  drives shifter ShiftEn
- NumShift  out  5  drives shifter NumShift; 0 whenever ShiftEn=0
- ShifterReady  in  1  from shifter BarrelShifterReady
- BitsUsed  out  24  bits consumed this run
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle pulse on run end
- Overrun  out  1  sticky; run ended because a request exceeded budget
- LenError  out  1  sticky; run ended on ReqLen > 16

## Operation
- All outputs are registered. Reset values are all 0, and the round-robin pointer resets to requester 0.
- States: IDLE, FILL, SETTLE, RUN, SHIFT, END.
- IDLE:
  - Start=1: latch BitBudget, clear BitsUsed, Overrun and LenError, set ShifterEnable=1, go to FILL.
- FILL:
  - Wait for ShifterReady=1, then go to SETTLE.
  - Stop in FILL goes to END.
- SETTLE: one cycle, so the registered shifter output catches up. Then go to RUN with WindowValid=1.
- RUN, arbitration:
  - Priority starts at the pointer and proceeds upward, mod 4.
  - If Stop=1, go to END without arbitrating, even when Req≠0.
  - If the winner's Len > 16, set LenError and go to END with no grant.
  - If BitsUsed+Len > budget, set Overrun and go to END with no grant.
  - Otherwise, next cycle: Grant[w]=1, ShiftEn=1, NumShift=Len, BitsUsed+=Len, pointer=w+1 mod 4, WindowValid=0, state SHIFT.
  - If Req=0, stay in RUN.
- SHIFT: one cycle (the grant cycle); then SETTLE. WindowValid returns 2 cycles after the grant cycle.
- END:
  - One cycle with Done=1; ShifterEnable=0.
  - Return to IDLE. Busy drops with the IDLE transition.
- Len=0 is a legal grant: it performs a shift-by-0 and follows the full SHIFT/SETTLE timing.
- BitsUsed+Len is computed at 25 bits, so the compare cannot wrap. A run that consumes exactly BitBudget is legal.
- Requester protocol:
  - A requester keeps Req=1 and ReqLen stable until it sees Grant.
  - It deasserts Req in the cycle after Grant.
  - Req seen in the SHIFT or SETTLE cycles is not arbitrated.
- ShifterEnable stays 1 from FILL through the END cycle.
- nReset mid-run: all state returns to reset values immediately, ShifterEnable drops, and no Done is produced.

## Timing
- Start at cycle 0 → FILL at 1. ShifterReady at cycle R → SETTLE at R+1 → RUN with WindowValid=1 at R+2.
- Request sampled in RUN at cycle t → Grant/ShiftEn/NumShift at t+1 → WindowValid=1 at t+3.
- Maximum throughput is one shift per 3 cycles.
- Done is asserted 1 cycle after the terminating condition is sampled; IDLE follows 1 cycle later.
- Start while Busy is ignored. Stop and Start together in IDLE: Start wins, and Stop is honored in FILL.

## Test plan
- Cold start:
  - Stimulus: Start, BitBudget=100, ShifterReady rises 10 cycles later.
  - Response: ShifterEnable=1 one cycle after Start; WindowValid=1 exactly 2 cycles after ShifterReady is sampled.
- Round-robin:
  - Stimulus: Req=4'b1111 held, every ReqLen=3.
  - Response: grants in order 0,1,2,3,0 at 3-cycle spacing; BitsUsed=15 after 5 grants; NumShift=0 between grants.
- Budget edge:
  - Stimulus: BitBudget=16; requester 1 asks for 16, then requester 2 asks for 1.
  - Response: the first is granted with BitsUsed=16; the second gets no grant, Overrun=1, a Done pulse, then IDLE.
- Illegal length:
  - Stimulus: ReqLen for requester 3 = 17.
  - Response: no Grant, LenError=1, Done, ShifterEnable=0.
- Stop during traffic:
  - Stimulus: Stop=1 while Req=4'b0010 in RUN.
  - Response: no grant, Done next cycle, BitsUsed holds its value.
- Reset mid-run:
  - Stimulus: nReset low in SHIFT.
  - Response: all outputs 0 asynchronously, no Done; a subsequent Start restarts the arbitration pointer at requester 0.
